// File: rtl/regfile_wr_arbiter.sv
// Write-port sequencer for the 4-entry register file: arbitrates requesters A and B,
// runs the clear sequence, turns idle cycles into refresh writes and forwards pending data to A.
module regfile_wr_arbiter #(
    parameter int              DW         = 16,
    parameter int              AW         = 2,
    parameter int              AUTO_CLEAR = 1,
    parameter logic [DW-1:0]   CLR_VAL    = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wvalid_a,
    input  logic [AW-1:0] wdest_a,
    input  logic [DW-1:0] wdata_a,
    output logic          wready_a,
    input  logic          wvalid_b,
    input  logic [AW-1:0] wdest_b,
    input  logic [DW-1:0] wdata_b,
    output logic          wready_b,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    input  logic [AW-1:0] rsel_a,
    output logic [DW-1:0] rdata_a,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_result,
    output logic [AW-1:0] rf_rs,
    input  logic [DW-1:0] rf_o_b,
    input  logic [DW-1:0] rf_o_r0,
    input  logic [DW-1:0] rf_o_r1,
    input  logic [DW-1:0] rf_o_r2,
    input  logic [DW-1:0] rf_o_r3
);

    localparam int          NREG      = 2 ** AW;
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_INIT  = (AUTO_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] wr_rd_q;
    logic [DW-1:0] wr_data_q;
    logic          wr_pend;
    logic          rr_ptr;
    logic          clr_done_q;

    logic          arb_open;
    logic          grant_a;
    logic          grant_b;
    logic [DW-1:0] hold_val;
    logic [DW-1:0] o_r [4];

    assign o_r[0] = rf_o_r0;
    assign o_r[1] = rf_o_r1;
    assign o_r[2] = rf_o_r2;
    assign o_r[3] = rf_o_r3;

    // rr_ptr only breaks ties; a lone requester is granted regardless of it.
    always_comb begin
        arb_open = rst_n && (state == ST_RUN) && !clr_req;
        grant_a  = arb_open && wvalid_a && (!wvalid_b || !rr_ptr);
        grant_b  = arb_open && wvalid_b && (!wvalid_a ||  rr_ptr);
    end

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        hold_val = '0;
        for (int i = 0; i < 4; i++) begin
            if (wr_rd_q == AW'(i)) hold_val = o_r[i];
        end
    end

    assign wready_a = grant_a;
    assign wready_b = grant_b;
    assign busy     = (state == ST_CLEAR);
    assign clr_done = clr_done_q;

    // The register file writes every cycle, so an idle slot rewrites the addressed entry with itself.
    assign rf_rd     = wr_rd_q;
    assign rf_result = !rst_n  ? '0
                     : wr_pend ? wr_data_q
                     :           hold_val;

    assign rf_rs   = rsel_a;
    assign rdata_a = (wr_pend && (wr_rd_q == rsel_a)) ? wr_data_q : rf_o_b;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            clr_cnt    <= '0;
            wr_pend    <= 1'b0;
            wr_rd_q    <= '0;
            wr_data_q  <= '0;
            rr_ptr     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            if (state == ST_CLEAR) begin
                wr_rd_q   <= clr_cnt;
                wr_data_q <= CLR_VAL;
                wr_pend   <= 1'b1;
                clr_cnt   <= clr_cnt + 1'b1;
                if (clr_cnt == LAST_REG) begin
                    state      <= ST_RUN;
                    clr_done_q <= 1'b1;
                end
            end else if (clr_req) begin
                state   <= ST_CLEAR;
                clr_cnt <= '0;
                wr_pend <= 1'b0;
            end else if (grant_a) begin
                wr_rd_q   <= wdest_a;
                wr_data_q <= wdata_a;
                wr_pend   <= 1'b1;
                rr_ptr    <= 1'b1;
            end else if (grant_b) begin
                wr_rd_q   <= wdest_b;
                wr_data_q <= wdata_b;
                wr_pend   <= 1'b1;
                rr_ptr    <= 1'b0;
            end else begin
                wr_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a behavioural 4x16 register file with no write enable
// sits on the write/read ports, and each task checks one behaviour against hand-computed values.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wvalid_a;
    logic [1:0]  wdest_a;
    logic [15:0] wdata_a;
    logic        wready_a;
    logic        wvalid_b;
    logic [1:0]  wdest_b;
    logic [15:0] wdata_b;
    logic        wready_b;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic [1:0]  rsel_a;
    logic [15:0] rdata_a;
    logic [1:0]  rf_rd;
    logic [15:0] rf_result;
    logic [1:0]  rf_rs;
    logic [15:0] rf_o_b;
    logic [15:0] rf_o_r0;
    logic [15:0] rf_o_r1;
    logic [15:0] rf_o_r2;
    logic [15:0] rf_o_r3;

    int tests = 0;
    int fails = 0;
    int viol_cnt = 0;

    regfile_wr_arbiter #(
        .DW(16), .AW(2), .AUTO_CLEAR(1), .CLR_VAL(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wvalid_a(wvalid_a), .wdest_a(wdest_a), .wdata_a(wdata_a), .wready_a(wready_a),
        .wvalid_b(wvalid_b), .wdest_b(wdest_b), .wdata_b(wdata_b), .wready_b(wready_b),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
        .rsel_a(rsel_a), .rdata_a(rdata_a),
        .rf_rd(rf_rd), .rf_result(rf_result), .rf_rs(rf_rs), .rf_o_b(rf_o_b),
        .rf_o_r0(rf_o_r0), .rf_o_r1(rf_o_r1), .rf_o_r2(rf_o_r2), .rf_o_r3(rf_o_r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: captures rf_result into rf_rd on every rising edge; seeded with non-zero junk.
    logic [15:0] regs [4] = '{16'hDEA0, 16'hDEA1, 16'hDEA2, 16'hDEA3};
    always @(posedge clk) regs[rf_rd] <= rf_result;
    assign rf_o_b  = regs[rf_rs];
    assign rf_o_r0 = regs[0];
    assign rf_o_r1 = regs[1];
    assign rf_o_r2 = regs[2];
    assign rf_o_r3 = regs[3];

    // Requester obligation monitor: an unaccepted request must keep its destination and data.
    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic [1:0]  hd_a, hd_b;
    logic [15:0] hw_a, hw_b;
    always @(posedge clk) begin
        if (hold_a && wvalid_a && (wdest_a !== hd_a || wdata_a !== hw_a)) begin
            viol_cnt <= viol_cnt + 1;
            $display("[TB] requester A changed an unaccepted request at %0t", $time);
        end
        if (hold_b && wvalid_b && (wdest_b !== hd_b || wdata_b !== hw_b)) begin
            viol_cnt <= viol_cnt + 1;
            $display("[TB] requester B changed an unaccepted request at %0t", $time);
        end
        hold_a <= wvalid_a && !wready_a;
        hd_a   <= wdest_a;
        hw_a   <= wdata_a;
        hold_b <= wvalid_b && !wready_b;
        hd_b   <= wdest_b;
        hw_b   <= wdata_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects to be entered just after rst_n rises: four clear writes, one clr_done, all registers zero.
    task automatic check_clear_seq(input string tag);
        tests++;
        if (busy !== 1'b1 || rf_rd !== 2'd0) begin
            fails++;
            $display("FAIL %s release: busy=%b rf_rd=%0d expected busy=1 rf_rd=0", tag, busy, rf_rd);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            tests++;
            if (rf_rd !== 2'(k - 1) || rf_result !== 16'h0000) begin
                fails++;
                $display("FAIL %s clear write %0d: rf_rd=%0d rf_result=%h expected rf_rd=%0d rf_result=0000",
                         tag, k, rf_rd, rf_result, k - 1);
            end
            tests++;
            if (busy !== (k < 4) || clr_done !== (k == 4)) begin
                fails++;
                $display("FAIL %s clear status %0d: busy=%b clr_done=%b expected busy=%b clr_done=%b",
                         tag, k, busy, clr_done, k < 4, k == 4);
            end
        end
        step();
        tests++;
        if (busy !== 1'b0 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL %s after clear: busy=%b clr_done=%b expected 0 0", tag, busy, clr_done);
        end
        for (int r = 0; r < 4; r++) begin
            rsel_a = 2'(r);
            #1;
            tests++;
            if (rdata_a !== 16'h0000) begin
                fails++;
                $display("FAIL %s cleared r%0d: got %h expected 0000", tag, r, rdata_a);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if (wready_a !== 1'b0 || wready_b !== 1'b0 || busy !== 1'b1 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL reset status: wready_a=%b wready_b=%b busy=%b clr_done=%b expected 0 0 1 0",
                     wready_a, wready_b, busy, clr_done);
        end
        tests++;
        if (rf_rd !== 2'd0 || rf_result !== 16'h0000) begin
            fails++;
            $display("FAIL reset write port: rf_rd=%0d rf_result=%h expected 0 0000", rf_rd, rf_result);
        end
        step();
        step();
        rst_n = 1'b1;
        check_clear_seq("auto_clear");
    endtask

    task automatic test_single_write();
        wvalid_a = 1'b1;
        wdest_a  = 2'd2;
        wdata_a  = 16'hABCD;
        #1;
        tests++;
        if (wready_a !== 1'b1 || wready_b !== 1'b0) begin
            fails++;
            $display("FAIL single grant: wready_a=%b wready_b=%b expected 1 0", wready_a, wready_b);
        end
        step();
        wvalid_a = 1'b0;
        tests++;
        if (rf_rd !== 2'd2 || rf_result !== 16'hABCD) begin
            fails++;
            $display("FAIL single drive: rf_rd=%0d rf_result=%h expected 2 abcd", rf_rd, rf_result);
        end
        step();
        rsel_a = 2'd2;
        #1;
        tests++;
        if (rdata_a !== 16'hABCD) begin
            fails++;
            $display("FAIL single commit: r2=%h expected abcd", rdata_a);
        end
        repeat (3) step();
        tests++;
        if (rf_rd !== 2'd2 || rf_result !== 16'hABCD || rdata_a !== 16'hABCD) begin
            fails++;
            $display("FAIL refresh: rf_rd=%0d rf_result=%h r2=%h expected 2 abcd abcd",
                     rf_rd, rf_result, rdata_a);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        wvalid_a = 1'b1; wdest_a = 2'd1; wdata_a = 16'h1111;
        wvalid_b = 1'b1; wdest_b = 2'd3; wdata_b = 16'h3333;
        #1;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (wready_a !== (i % 2 == 0) || wready_b !== (i % 2 == 1)) begin
                fails++;
                $display("FAIL round robin cycle %0d: wready_a=%b wready_b=%b expected %b %b",
                         i, wready_a, wready_b, i % 2 == 0, i % 2 == 1);
            end
            step();
        end
        wvalid_a = 1'b0;
        wvalid_b = 1'b0;
        step();
        rsel_a = 2'd1;
        #1;
        tests++;
        if (rdata_a !== 16'h1111) begin
            fails++;
            $display("FAIL round robin r1: got %h expected 1111", rdata_a);
        end
        rsel_a = 2'd3;
        #1;
        tests++;
        if (rdata_a !== 16'h3333) begin
            fails++;
            $display("FAIL round robin r3: got %h expected 3333", rdata_a);
        end
    endtask

    task automatic test_forwarding();
        rsel_a   = 2'd0;
        wvalid_a = 1'b1; wdest_a = 2'd0; wdata_a = 16'h00FF;
        #1;
        tests++;
        if (wready_a !== 1'b1) begin
            fails++;
            $display("FAIL forward grant: wready_a=%b expected 1", wready_a);
        end
        step();
        wvalid_a = 1'b0;
        tests++;
        if (rdata_a !== 16'h00FF || rf_o_b !== 16'h0000) begin
            fails++;
            $display("FAIL forward pending: rdata_a=%h rf_o_b=%h expected 00ff 0000", rdata_a, rf_o_b);
        end
        rsel_a = 2'd1;
        #1;
        tests++;
        if (rdata_a !== 16'h1111) begin
            fails++;
            $display("FAIL forward other addr: rdata_a=%h expected 1111", rdata_a);
        end
        rsel_a = 2'd0;
        step();
        tests++;
        if (rdata_a !== 16'h00FF || rf_o_b !== 16'h00FF) begin
            fails++;
            $display("FAIL forward commit: rdata_a=%h rf_o_b=%h expected 00ff 00ff", rdata_a, rf_o_b);
        end
    endtask

    task automatic test_clear_request();
        wvalid_b = 1'b1; wdest_b = 2'd1; wdata_b = 16'h5A5A;
        #1;
        tests++;
        if (wready_b !== 1'b1) begin
            fails++;
            $display("FAIL clear req B grant: wready_b=%b expected 1", wready_b);
        end
        step();
        wvalid_b = 1'b0;
        clr_req  = 1'b1;
        wvalid_a = 1'b1; wdest_a = 2'd2; wdata_a = 16'h1234;
        #1;
        tests++;
        if (wready_a !== 1'b0 || wready_b !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clear req cycle: wready_a=%b wready_b=%b busy=%b expected 0 0 0",
                     wready_a, wready_b, busy);
        end
        tests++;
        if (rf_rd !== 2'd1 || rf_result !== 16'h5A5A) begin
            fails++;
            $display("FAIL clear req drive: rf_rd=%0d rf_result=%h expected 1 5a5a", rf_rd, rf_result);
        end
        step();
        clr_req  = 1'b0;
        wvalid_a = 1'b0;
        tests++;
        if (busy !== 1'b1 || rf_o_r1 !== 16'h5A5A) begin
            fails++;
            $display("FAIL clear req commit: busy=%b r1=%h expected 1 5a5a", busy, rf_o_r1);
        end
        repeat (3) step();
        tests++;
        if (busy !== 1'b1 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL clear req mid: busy=%b clr_done=%b expected 1 0", busy, clr_done);
        end
        step();
        tests++;
        if (busy !== 1'b0 || clr_done !== 1'b1) begin
            fails++;
            $display("FAIL clear req done: busy=%b clr_done=%b expected 0 1", busy, clr_done);
        end
        step();
        tests++;
        if (clr_done !== 1'b0) begin
            fails++;
            $display("FAIL clear req pulse width: clr_done=%b expected 0", clr_done);
        end
        for (int r = 0; r < 4; r++) begin
            rsel_a = 2'(r);
            #1;
            tests++;
            if (rdata_a !== 16'h0000) begin
                fails++;
                $display("FAIL clear req r%0d: got %h expected 0000", r, rdata_a);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        step();
        tests++;
        if (busy !== 1'b1 || rf_rd !== 2'd1) begin
            fails++;
            $display("FAIL mid clear progress: busy=%b rf_rd=%0d expected 1 1", busy, rf_rd);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b1 || rf_rd !== 2'd0 || rf_result !== 16'h0000 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL mid clear reset: busy=%b rf_rd=%0d rf_result=%h clr_done=%b expected 1 0 0000 0",
                     busy, rf_rd, rf_result, clr_done);
        end
        step();
        rst_n = 1'b1;
        check_clear_seq("restart");
    endtask

    initial begin
        rst_n    = 1'b0;
        wvalid_a = 1'b0; wdest_a = '0; wdata_a = '0;
        wvalid_b = 1'b0; wdest_b = '0; wdata_b = '0;
        clr_req  = 1'b0;
        rsel_a   = '0;

        test_reset();
        test_single_write();
        test_round_robin();
        test_forwarding();
        test_clear_request();
        test_reset_mid_clear();

        tests++;
        if (viol_cnt !== 0) begin
            fails++;
            $display("FAIL requester protocol: violations=%0d expected 0", viol_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
